ram8_bist: RTL and testbench

Built-in self-test engine and access port for the 8×16 `ram8`: it drives `ram8`'s `address`/`in`/`load` pins and checks its `out` pin. On `start` it writes a deterministic pattern to all eight words, reads them back, compares each word and reports pass/fail plus the first failing address. While idle, it forwards host accesses transparently to the RAM. It sits between the host logic and one `ram8` instance, in the same memory/program-counter subsystem.

---
 rtl/ram8_bist_pkg.sv | 15 +
 rtl/ram8_bist_pat.sv | 18 +
 rtl/ram8_bist.sv | 118 +++++++++++
 tb/tb_ram8_bist.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/ram8_bist_pkg.sv
// Shared constants and state encodings for the ram8 BIST engine.
package ram8_bist_pkg;

  localparam int RAM8_DEPTH = 8;
  localparam int RAM8_AW    = 3;
  localparam int RAM8_DW    = 16;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_WRITE     = 3'd1;
  localparam logic [2:0] ST_READ      = 3'd2;
  localparam logic [2:0] ST_DONE      = 3'd3;
  localparam logic [2:0] ST_WRITE_INV = 3'd4;
  localparam logic [2:0] ST_READ_INV  = 3'd5;

endpackage

// File: rtl/ram8_bist_pat.sv
// Test pattern generator: PATTERN_BASE + a (mod 2^16), optionally inverted.
// Shared by the write-data path and the read-compare path.
module ram8_bist_pat
  import ram8_bist_pkg::*;
#(
  parameter logic [RAM8_DW-1:0] PATTERN_BASE = 16'h1234
) (
  input  logic [RAM8_AW-1:0] a_i,
  input  logic               inv_i,
  output logic [RAM8_DW-1:0] pat_o
);

  logic [RAM8_DW-1:0] sum;

  assign sum   = PATTERN_BASE + {{(RAM8_DW-RAM8_AW){1'b0}}, a_i};
  assign pat_o = inv_i ? ~sum : sum;

endmodule

// File: rtl/ram8_bist.sv
// BIST engine and host access port for one ram8 instance.
// Optional inverted-data pass enabled by defining RAM8_BIST_INVERT_PASS_EN.
module ram8_bist
  import ram8_bist_pkg::*;
#(
  parameter logic [RAM8_DW-1:0] PATTERN_BASE = 16'h1234
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [RAM8_AW-1:0] host_address,
  input  logic [RAM8_DW-1:0] host_in,
  input  logic               host_load,
  output logic [RAM8_DW-1:0] host_out,
  output logic [RAM8_AW-1:0] ram_address,
  output logic [RAM8_DW-1:0] ram_in,
  output logic               ram_load,
  input  logic [RAM8_DW-1:0] ram_out,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [RAM8_AW-1:0] fail_addr
);

  localparam logic [RAM8_AW-1:0] LAST_A = RAM8_AW'(RAM8_DEPTH - 1);

  logic [2:0]         state_q, state_d;
  logic [RAM8_AW-1:0] a_q, a_d;
  logic               pass_q, pass_d;
  logic [RAM8_AW-1:0] fail_q, fail_d;
  logic               write_ph, inv_ph;
  logic [RAM8_DW-1:0] pat;

  assign write_ph = (state_q == ST_WRITE) || (state_q == ST_WRITE_INV);
  assign inv_ph   = (state_q == ST_WRITE_INV) || (state_q == ST_READ_INV);
  assign busy     = write_ph || (state_q == ST_READ) || (state_q == ST_READ_INV);
  assign done     = (state_q == ST_DONE);

  ram8_bist_pat #(.PATTERN_BASE(PATTERN_BASE)) u_pat (
    .a_i   (a_q),
    .inv_i (inv_ph),
    .pat_o (pat)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    pass_d  = pass_q;
    fail_d  = fail_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_WRITE;
          a_d     = '0;
          pass_d  = 1'b0;
          fail_d  = '0;
        end
      end
      ST_WRITE, ST_WRITE_INV: begin
        if (a_q == LAST_A) begin
          state_d = (state_q == ST_WRITE) ? ST_READ : ST_READ_INV;
          a_d     = '0;
        end else begin
          a_d = a_q + 3'd1;
        end
      end
      ST_READ, ST_READ_INV: begin
        // First mismatch aborts the run and latches its address.
        if (ram_out != pat) begin
          fail_d  = a_q;
          pass_d  = 1'b0;
          state_d = ST_DONE;
          a_d     = '0;
        end else if (a_q == LAST_A) begin
          a_d = '0;
`ifdef RAM8_BIST_INVERT_PASS_EN
          if (state_q == ST_READ) begin
            state_d = ST_WRITE_INV;
          end else begin
            pass_d  = 1'b1;
            state_d = ST_DONE;
          end
`else
          pass_d  = 1'b1;
          state_d = ST_DONE;
`endif
        end else begin
          a_d = a_q + 3'd1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      pass_q  <= 1'b0;
      fail_q  <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
    end
  end

  // Host owns the RAM port whenever no test phase is active, DONE included.
  assign ram_address = busy ? a_q : host_address;
  assign ram_in      = busy ? pat : host_in;
  assign ram_load    = busy ? write_ph : host_load;
  assign host_out    = ram_out;
  assign pass        = pass_q;
  assign fail_addr   = fail_q;

endmodule

// File: tb/tb_ram8_bist.sv
// Directed bench for ram8_bist with a behavioural ram8 model (optional stuck-at fault).
module tb_ram8_bist;

`ifdef RAM8_BIST_INVERT_PASS_EN
  localparam logic [15:0] BASE   = 16'hFFFC;
  localparam int          DCYC   = 33;
  localparam int          HOLD   = 72;
  localparam logic [15:0] EXP_W5 = 16'hFFFE;
  localparam logic [15:0] EXP_W2 = 16'h0001;
`else
  localparam logic [15:0] BASE   = 16'h1234;
  localparam int          DCYC   = 17;
  localparam int          HOLD   = 40;
  localparam logic [15:0] EXP_W5 = 16'h1239;
  localparam logic [15:0] EXP_W2 = 16'h1236;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  host_address;
  logic [15:0] host_in;
  logic        host_load;
  logic [15:0] host_out;
  logic [2:0]  ram_address;
  logic [15:0] ram_in;
  logic        ram_load;
  logic [15:0] ram_out;
  logic        busy, done, pass;
  logic [2:0]  fail_addr;

  logic [15:0] mem [8];
  logic        fault;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  ram8_bist #(.PATTERN_BASE(BASE)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .host_address (host_address),
    .host_in      (host_in),
    .host_load    (host_load),
    .host_out     (host_out),
    .ram_address  (ram_address),
    .ram_in       (ram_in),
    .ram_load     (ram_load),
    .ram_out      (ram_out),
    .busy         (busy),
    .done         (done),
    .pass         (pass),
    .fail_addr    (fail_addr)
  );

  always @(posedge clk) begin
    if (ram_load) mem[ram_address] <= ram_in;
  end

  assign ram_out = mem[ram_address] & ((fault && ram_address == 3'd3) ? 16'hFFFE : 16'hFFFF);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Pulse/hold start from edge E0, then observe cycles 1..ncyc at mid-cycle.
  task automatic run(input int hold, input int rst_at, input int ncyc, input bit hw,
                     output int d1, output int d2, output int dcnt,
                     output int bcnt, output int bfirst, output int blast);
    d1 = 0; d2 = 0; dcnt = 0; bcnt = 0; bfirst = 0; blast = 0;
    @(negedge clk);
    start = 1'b1;
    if (hw) begin host_load = 1'b0; host_address = 3'd2; host_in = 16'hDEAD; end
    @(posedge clk);
    for (int n = 1; n <= ncyc; n++) begin
      @(negedge clk);
      if (busy) begin bcnt++; if (bfirst == 0) bfirst = n; blast = n; end
      if (done) begin dcnt++; if (d1 == 0) d1 = n; else if (d2 == 0) d2 = n; end
      if (n >= hold) start = 1'b0;
      if (hw) host_load = busy;
      if (n == rst_at) begin
        reset = 1'b1;
        #1;
        check("rst_mid_busy", busy, 0);
        check("rst_mid_done", done, 0);
        check("rst_mid_pass", pass, 0);
        check("rst_mid_fail_addr", fail_addr, 0);
        check("rst_mid_ram_load", ram_load, host_load);
        check("rst_mid_ram_address", ram_address, host_address);
      end
      if (rst_at > 0 && n == rst_at + 2) reset = 1'b0;
    end
    host_load = 1'b0;
  endtask

  task automatic wait_idle();
    int quiet = 0;
    for (int n = 0; n < 400 && quiet < 2; n++) begin
      @(negedge clk);
      if (!busy && !done) quiet++;
      else quiet = 0;
    end
    check("drain_idle", quiet >= 2, 1);
  endtask

  int d1, d2, dcnt, bcnt, bfirst, blast;

  initial begin
    for (int i = 0; i < 8; i++) mem[i] = 16'h0000;
    fault = 1'b0;
    reset = 1'b1;
    start = 1'b0;
    host_address = 3'd6;
    host_in = 16'h0000;
    host_load = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_fail_addr", fail_addr, 0);
    check("rst_ram_load", ram_load, 1);
    check("rst_ram_address", ram_address, 3'd6);
    host_load = 1'b0;
    @(negedge clk);
    reset = 1'b0;

    // Idle host write then read-back through the mux.
    @(negedge clk);
    host_load = 1'b1; host_address = 3'd5; host_in = 16'hBEEF;
    @(negedge clk);
    host_load = 1'b0;
    #1;
    check("host_rw", host_out, 16'hBEEF);

    // Fault-free run.
    run(1, 0, DCYC + 3, 1'b0, d1, d2, dcnt, bcnt, bfirst, blast);
    check("pass_done_cycle", d1, DCYC);
    check("pass_done_count", dcnt, 1);
    check("pass_busy_first", bfirst, 1);
    check("pass_busy_last", blast, DCYC - 1);
    check("pass_busy_count", bcnt, DCYC - 1);
    check("pass_flag", pass, 1);
    check("pass_fail_addr", fail_addr, 0);
    check("pass_word5", mem[5], EXP_W5);

    // Bit 0 stuck at 0 at address 3.
    fault = 1'b1;
    run(1, 0, 20, 1'b0, d1, d2, dcnt, bcnt, bfirst, blast);
    fault = 1'b0;
    check("fault_done_cycle", d1, 13);
    check("fault_pass", pass, 0);
    check("fault_fail_addr", fail_addr, 3'd3);

    // Reset in cycle 5 abandons the run; a fresh run then passes.
    host_address = 3'd6; host_in = 16'h0000; host_load = 1'b0;
    run(1, 5, 40, 1'b0, d1, d2, dcnt, bcnt, bfirst, blast);
    check("rst_mid_no_done", dcnt, 0);
    run(1, 0, DCYC + 3, 1'b0, d1, d2, dcnt, bcnt, bfirst, blast);
    check("after_rst_done_cycle", d1, DCYC);
    check("after_rst_pass", pass, 1);

    // start held high: back-to-back runs.
    run(HOLD, 0, 2 * DCYC + 2, 1'b0, d1, d2, dcnt, bcnt, bfirst, blast);
    start = 1'b0;
    check("b2b_done1", d1, DCYC);
    check("b2b_done2", d2, 2 * DCYC + 1);
    wait_idle();

    // Host writes while busy must not reach the RAM.
    run(1, 0, DCYC + 3, 1'b1, d1, d2, dcnt, bcnt, bfirst, blast);
    check("hostbusy_pass", pass, 1);
    check("hostbusy_word2", mem[2], EXP_W2);
    check("hostbusy_word5", mem[5], EXP_W5);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
